perceptron_train_ctrl: RTL

//   Epoch-level training sequencer for the two-input neuron datapath (x1/x2/T/W1/W2/B/flag registers).

---
 rtl/perceptron_train_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/perceptron_train_ctrl.sv
// Epoch-level training sequencer for a two-input perceptron datapath.
// Optional ERR_CNT_EN macro adds err_cnt, the update count of the last completed epoch.
module perceptron_train_ctrl #(
  parameter int N_SAMPLES = 4,
  parameter int ADDR_W    = 2,
  parameter int MAX_EPOCH = 15,
  parameter int EPOCH_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mismatch,
  output logic [ADDR_W-1:0]  sample_addr,
  output logic               clr_w,
  output logic               ld_x,
  output logic               ld_t,
  output logic               ld_w,
  output logic               ld_b,
  output logic               busy,
  output logic               done,
  output logic               converged,
`ifdef ERR_CNT_EN
  output logic [ADDR_W:0]    err_cnt,
`endif
  output logic [EPOCH_W-1:0] epoch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_EVAL, S_UPDATE, S_NEXT, S_CHECK, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] MAX_E     = EPOCH_W'(MAX_EPOCH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic                changed_q, changed_d;
  logic                conv_q, conv_d;
  logic                clr_w_q, ld_x_q, ld_w_q, busy_q, done_q;
`ifdef ERR_CNT_EN
  logic [ADDR_W:0]     run_err_q, run_err_d;
  logic [ADDR_W:0]     err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    epoch_d   = epoch_q;
    changed_d = changed_q;
    conv_d    = conv_q;
`ifdef ERR_CNT_EN
    run_err_d = run_err_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_INIT: begin
        // Run state is cleared on entry to INIT so the stale result vanishes as clr_w pulses.
        if (state_q == S_INIT || start) begin
          state_d   = (state_q == S_INIT) ? S_FETCH : S_INIT;
          addr_d    = '0;
          epoch_d   = '0;
          changed_d = 1'b0;
          conv_d    = 1'b0;
`ifdef ERR_CNT_EN
          run_err_d = '0;
          err_d     = '0;
`endif
        end
      end
      S_FETCH:  state_d = S_EVAL;
      S_EVAL:   state_d = mismatch ? S_UPDATE : S_NEXT;
      S_UPDATE: begin
        changed_d = 1'b1;
`ifdef ERR_CNT_EN
        run_err_d = run_err_q + 1'b1;
`endif
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_CHECK: begin
        epoch_d = epoch_q + 1'b1;
`ifdef ERR_CNT_EN
        err_d     = run_err_q;
        run_err_d = '0;
`endif
        if (!changed_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (epoch_q + 1'b1 == MAX_E) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          changed_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet still Moore-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      epoch_q   <= '0;
      changed_q <= 1'b0;
      conv_q    <= 1'b0;
      clr_w_q   <= 1'b0;
      ld_x_q    <= 1'b0;
      ld_w_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ERR_CNT_EN
      run_err_q <= '0;
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      epoch_q   <= epoch_d;
      changed_q <= changed_d;
      conv_q    <= conv_d;
      clr_w_q   <= (state_d == S_INIT);
      ld_x_q    <= (state_d == S_FETCH);
      ld_w_q    <= (state_d == S_UPDATE);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q    <= (state_d == S_DONE);
`ifdef ERR_CNT_EN
      run_err_q <= run_err_d;
      err_q     <= err_d;
`endif
    end
  end

  assign sample_addr = addr_q;
  assign epoch_cnt   = epoch_q;
  assign converged   = conv_q;
  assign clr_w       = clr_w_q;
  assign ld_x        = ld_x_q;
  assign ld_t        = ld_x_q;
  assign ld_w        = ld_w_q;
  assign ld_b        = ld_w_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef ERR_CNT_EN
  assign err_cnt     = err_q;
`endif

endmodule
